// File: rtl/vertex_stream_ctrl.sv
// vertex_stream_ctrl: streams L source vertices through the transform pipeline and writes the results to destination memory.
// Optional VERTEX_STREAM_DOUBLE_BUFFER_EN alternates the destination bank after every non-empty job.
module vertex_stream_ctrl #(
    parameter int DATA_W    = 18,
    parameter int OUT_W     = 11,
    parameter int DEPTH     = 16384,
    parameter int PRIM_SIZE = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       vertex_count,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     src_rd_addr,
    input  logic [DATA_W-1:0] src_rd_data,
    output logic [DATA_W-1:0] xf_in_data,
    output logic              xf_in_valid,
    input  logic              xf_in_ready,
    input  logic [OUT_W-1:0]  xf_out_data,
    input  logic              xf_out_valid,
    output logic              dst_wr_en,
    output logic [AW:0]       dst_wr_addr,
    output logic [OUT_W-1:0]  dst_wr_data,
    output logic              raster_start,
    output logic [31:0]       raster_count,
    output logic              bank_sel,
    output logic              error
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    localparam logic [31:0] MAX_L = 32'(DEPTH - DEPTH % PRIM_SIZE);
    state_t state, state_next;
    logic [31:0] vc_floor;
    logic [AW:0] len, len_new, rd_cnt, pop_cnt, res_cnt;
    logic [DATA_W-1:0] fifo [2];
    logic [1:0] fifo_cnt;
    logic [2:0] occ;
    logic [31:0] rc_q;
    logic wr_ptr, rd_ptr, rd_pend, pop, issue, accept, wr_bank, bank_q;

    assign vc_floor = vertex_count - vertex_count % 32'(PRIM_SIZE);
    assign len_new = (AW+1)'(vc_floor > MAX_L ? MAX_L : vc_floor);
    assign busy = state == FETCH || state == DRAIN;
    assign done = state == DONE;
    assign raster_start = done && len != 0;
    assign raster_count = done ? 32'(len) : rc_q;
    assign bank_sel = done ? wr_bank : bank_q;
    assign xf_in_valid = fifo_cnt != 0;
    assign xf_in_data = fifo[rd_ptr];
    assign src_rd_addr = rd_cnt[AW-1:0];
    assign pop = xf_in_valid && xf_in_ready;
    // occupancy after this cycle's pop, so a steady stream keeps one read per cycle
    assign occ = 3'(fifo_cnt) + 3'(rd_pend) - 3'(pop);
    // the first read goes out in the accepting cycle to reach xf_in_valid two cycles later
    assign issue = (state == IDLE && start && len_new != 0) || (state == FETCH && rd_cnt < len && occ <= 3'd1);
    assign accept = busy && xf_out_valid && res_cnt < len;

    always_comb begin
        state_next = state == IDLE  ? (start ? (len_new != 0 ? FETCH : DONE) : IDLE)
                   : state == FETCH ? (pop && pop_cnt + 1'b1 == len ? DRAIN : FETCH)
                   : state == DRAIN ? (res_cnt == len ? DONE : DRAIN)
                   : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            len         <= '0;
            rd_cnt      <= '0;
            pop_cnt     <= '0;
            res_cnt     <= '0;
            rd_pend     <= 1'b0;
            fifo_cnt    <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo[0]     <= '0;
            fifo[1]     <= '0;
            dst_wr_en   <= 1'b0;
            dst_wr_addr <= '0;
            dst_wr_data <= '0;
            rc_q        <= '0;
            bank_q      <= 1'b0;
            error       <= 1'b0;
        end else begin
            state   <= state_next;
            rd_pend <= issue;
            if (state == IDLE && start)
                len <= len_new;
            if (state == DONE) begin
                rd_cnt  <= '0;
                pop_cnt <= '0;
                res_cnt <= '0;
                rc_q    <= 32'(len);
                bank_q  <= wr_bank;
            end else begin
                if (issue)
                    rd_cnt <= rd_cnt + 1'b1;
                if (pop)
                    pop_cnt <= pop_cnt + 1'b1;
                if (accept)
                    res_cnt <= res_cnt + 1'b1;
            end
            if (rd_pend) begin
                fifo[wr_ptr] <= src_rd_data;
                wr_ptr       <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            fifo_cnt  <= fifo_cnt + 2'(rd_pend) - 2'(pop);
            dst_wr_en <= accept;
            if (accept) begin
                dst_wr_addr <= {wr_bank, res_cnt[AW-1:0]};
                dst_wr_data <= xf_out_data;
            end
            if (xf_out_valid && !accept)
                error <= 1'b1;
        end
    end

`ifdef VERTEX_STREAM_DOUBLE_BUFFER_EN
    always_ff @(posedge clk) begin
        if (reset)
            wr_bank <= 1'b0;
        else if (done && len != 0)
            wr_bank <= !wr_bank;
    end
`else
    assign wr_bank = 1'b0;
`endif
endmodule

// File: tb/tb_vertex_stream_ctrl.sv
// tb_vertex_stream_ctrl: table-driven and randomized jobs against a queue-based reference of the fetch/transform/write flow.
module tb_vertex_stream_ctrl;
    localparam int DW = 18, OW = 11, DEPTH = 16, AW = 4, LAT = 5;
`ifdef VERTEX_STREAM_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    typedef struct {logic [31:0] vc; int mode; int exp_l;} vec_t;
    typedef struct {int due; logic [OW-1:0] d;} res_t;

    logic clk = 1'b0;
    logic reset, start, busy, done, xf_in_valid, xf_in_ready, xf_out_valid;
    logic dst_wr_en, raster_start, bank_sel, error;
    logic [31:0] vertex_count, raster_count;
    logic [AW-1:0] src_rd_addr;
    logic [DW-1:0] src_rd_data, xf_in_data;
    logic [OW-1:0] xf_out_data, dst_wr_data;
    logic [AW:0] dst_wr_addr;

    vertex_stream_ctrl #(.DATA_W(DW), .OUT_W(OW), .DEPTH(DEPTH), .PRIM_SIZE(4)) dut (
        .clk(clk), .reset(reset), .start(start), .vertex_count(vertex_count),
        .busy(busy), .done(done), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
        .xf_in_data(xf_in_data), .xf_in_valid(xf_in_valid), .xf_in_ready(xf_in_ready),
        .xf_out_data(xf_out_data), .xf_out_valid(xf_out_valid),
        .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
        .raster_start(raster_start), .raster_count(raster_count), .bank_sel(bank_sel), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [DEPTH];
    res_t pipe_q[$];
    int errors = 0, checks = 0;
    int ready_mode = 0, cur_l = 0, pop_idx = 0, wr_idx = 0, first_pop = -1, last_pop = -1;
    bit exp_bank = 1'b0, tgl = 1'b0;
    logic [AW-1:0] last_addr = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] xf(input logic [DW-1:0] d);
        return d[10:0] ^ d[17:7];
    endfunction

    function automatic int model_len(input logic [31:0] vc);
        longint f = longint'(vc) / 4 * 4;
        longint m = DEPTH / 4 * 4;
        return int'(f > m ? m : f);
    endfunction

    // environment: registered source memory, ready pattern, fixed-latency echo transform, scoreboard
    always @(negedge clk) begin
        src_rd_data = mem[last_addr];
        last_addr = src_rd_addr;
        tgl = !tgl;
        xf_in_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? tgl : 1'($urandom_range(0, 1));
        xf_out_valid = 1'b0;
        xf_out_data = '0;
        if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
            xf_out_valid = 1'b1;
            xf_out_data = pipe_q[0].d;
            void'(pipe_q.pop_front());
        end
        if (busy && cur_l < DEPTH)
            check("outstanding_le_2", longint'(int'(src_rd_addr) - pop_idx <= 2), 1);
        if (xf_in_valid && xf_in_ready) begin
            pipe_q.push_back('{cyc + LAT, xf(xf_in_data)});
            check("pop_in_range", longint'(pop_idx < cur_l), 1);
            if (pop_idx < cur_l)
                check("xf_in_data", xf_in_data, mem[pop_idx]);
            if (first_pop < 0)
                first_pop = cyc;
            last_pop = cyc;
            pop_idx++;
        end
        if (dst_wr_en) begin
            check("wr_in_range", longint'(wr_idx < cur_l), 1);
            if (wr_idx < cur_l) begin
                check("dst_wr_addr", dst_wr_addr, exp_bank * DEPTH + wr_idx);
                check("dst_wr_data", dst_wr_data, xf(mem[wr_idx]));
            end
            wr_idx++;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_xf_in_valid"}, xf_in_valid, 0);
        check({tag, "_dst_wr_en"}, dst_wr_en, 0);
        check({tag, "_raster_start"}, raster_start, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_bank_sel"}, bank_sel, 0);
        check({tag, "_raster_count"}, raster_count, 0);
        check({tag, "_dst_wr_addr"}, dst_wr_addr, 0);
        check({tag, "_dst_wr_data"}, dst_wr_data, 0);
        check({tag, "_src_rd_addr"}, src_rd_addr, 0);
        check({tag, "_xf_in_data"}, xf_in_data, 0);
    endtask

    task automatic run_job(input logic [31:0] vc, input int mode, input int exp_l);
        bit got = 1'b0;
        int start_cyc;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        ready_mode = mode;
        cur_l = exp_l;
        pop_idx = 0;
        wr_idx = 0;
        first_pop = -1;
        last_pop = -1;
        start = 1'b1;
        vertex_count = vc;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (exp_l == 0) begin
            got = done;
            check("done_after_start_l0", done, 1);
            check("raster_start_l0", raster_start, 0);
        end else begin
            check("busy_after_start", busy, 1);
            check("xf_in_valid_early", xf_in_valid, 0);
            @(negedge clk);
            check("xf_in_valid_at_2", xf_in_valid, 1);
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (done) begin
                    got = 1'b1;
                    break;
                end
            end
            check("done_seen", got, 1);
            check("raster_start", raster_start, 1);
            check("busy_in_done", busy, 0);
        end
        check("raster_count", raster_count, exp_l);
        check("bank_sel", bank_sel, exp_bank);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("pops", pop_idx, exp_l);
        check("writes", wr_idx, exp_l);
        check("raster_count_hold", raster_count, exp_l);
        check("error_clear", error, 0);
        if (mode == 0 && exp_l > 0) begin
            check("first_pop_latency", first_pop - start_cyc, 2);
            check("throughput", last_pop - first_pop, exp_l - 1);
        end
        if (DB && exp_l > 0)
            exp_bank = !exp_bank;
    endtask

    initial begin
        vec_t tbl[12];
        logic [31:0] vc;
        int mode;
        tbl[0]  = '{32'd10, 0, 8};
        tbl[1]  = '{32'd12, 1, 12};
        tbl[2]  = '{32'd3, 0, 0};
        tbl[3]  = '{32'hFFFF_FFFF, 0, 16};
        tbl[4]  = '{32'd0, 0, 0};
        tbl[5]  = '{32'd7, 2, 4};
        tbl[6]  = '{32'd16, 1, 16};
        tbl[7]  = '{32'd17, 2, 16};
        tbl[8]  = '{32'd5, 0, 4};
        tbl[9]  = '{32'd20, 2, 16};
        tbl[10] = '{32'd15, 1, 12};
        tbl[11] = '{32'd4, 0, 4};
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        reset = 1'b1;
        start = 1'b0;
        vertex_count = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        for (int i = 0; i < 12; i++) run_job(tbl[i].vc, tbl[i].mode, tbl[i].exp_l);

        // reset in the middle of FETCH, then results still emerging from the transform
        ready_mode = 0;
        cur_l = 12;
        pop_idx = 0;
        wr_idx = 0;
        start = 1'b1;
        vertex_count = 32'd12;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_mid_fetch", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cur_l = 0;
        exp_bank = 1'b0;
        check_reset_vals("mid_reset");
        repeat (12) @(negedge clk);
        check("stray_error", error, 1);
        check("stray_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("error_sticky", error, 1);
        reset = 1'b1;
        start = 1'b1;
        vertex_count = 32'd8;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("error_cleared_by_reset", error, 0);
        check("reset_over_start_busy", busy, 0);
        @(negedge clk);
        check("reset_over_start_busy2", busy, 0);
        check("reset_over_start_done", done, 0);

        for (int j = 0; j < 20; j++) begin
            vc = $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, 24));
            mode = $urandom_range(0, 2);
            run_job(vc, mode, model_len(vc));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
